// File: rtl/instruction_encoder.sv
// instruction_encoder
//   RV32I instruction encoder. A decoded operation select plus register and
//   immediate fields are assembled combinationally into a 32-bit machine word,
//   which is written into a small output FIFO (DEPTH entries, power of two,
//   minimum 2). Illegal operation selects (40..63) are still accepted and are
//   stored as word=0 with the illegal flag set.
//
//   Optional build macro: INSTRUCTION_ENCODER_RANGE_CHECK_EN
//     defined   : entries whose immediate does not fit the format are flagged
//                 illegal; the word still carries the truncated immediate.
//     undefined : immediates are silently truncated.
//
//   Handshake: a transfer happens on a rising edge when valid && ready on that
//   side. in_ready depends only on the fill level (not on out_ready). There is
//   no bypass: a word becomes visible on out_* the cycle after it is accepted.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake
//   in_op               operation select (0..39 legal)
//   in_rd/in_rs1/in_rs2 register indices
//   in_imm              signed byte-offset immediate (U-type: full upper value)
//   out_valid/out_ready result handshake
//   out_word            encoded instruction at the FIFO head
//   out_illegal         head entry flagged illegal
module instruction_encoder #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        out_illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  // Instruction formats
  localparam logic [2:0] F_R  = 3'd0;
  localparam logic [2:0] F_I  = 3'd1;
  localparam logic [2:0] F_S  = 3'd2;
  localparam logic [2:0] F_B  = 3'd3;
  localparam logic [2:0] F_U  = 3'd4;
  localparam logic [2:0] F_J  = 3'd5;
  localparam logic [2:0] F_SH = 3'd6;
  localparam logic [2:0] F_FX = 3'd7;

  // Major opcodes
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LD    = 7'b0000011;
  localparam logic [6:0] OPC_ST    = 7'b0100011;
  localparam logic [6:0] OPC_OPI   = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  logic [2:0]  fmt;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] fixed_word;
  logic        op_bad;
  logic [31:0] word;
  logic [31:0] enc_word;
  logic        enc_illegal;

  // Operation select -> format and constant fields
  always_comb begin
    fmt        = F_FX;
    opc        = '0;
    f3         = '0;
    f7         = '0;
    fixed_word = '0;
    op_bad     = 1'b0;
    case (in_op)
      6'd0:  begin fmt = F_U;  opc = OPC_LUI;   end
      6'd1:  begin fmt = F_U;  opc = OPC_AUIPC; end
      6'd2:  begin fmt = F_J;  opc = OPC_JAL;   end
      6'd3:  begin fmt = F_I;  opc = OPC_JALR;  f3 = 3'd0; end
      6'd4:  begin fmt = F_B;  opc = OPC_BR;    f3 = 3'd0; end
      6'd5:  begin fmt = F_B;  opc = OPC_BR;    f3 = 3'd1; end
      6'd6:  begin fmt = F_B;  opc = OPC_BR;    f3 = 3'd4; end
      6'd7:  begin fmt = F_B;  opc = OPC_BR;    f3 = 3'd5; end
      6'd8:  begin fmt = F_B;  opc = OPC_BR;    f3 = 3'd6; end
      6'd9:  begin fmt = F_B;  opc = OPC_BR;    f3 = 3'd7; end
      6'd10: begin fmt = F_I;  opc = OPC_LD;    f3 = 3'd0; end
      6'd11: begin fmt = F_I;  opc = OPC_LD;    f3 = 3'd1; end
      6'd12: begin fmt = F_I;  opc = OPC_LD;    f3 = 3'd2; end
      6'd13: begin fmt = F_I;  opc = OPC_LD;    f3 = 3'd4; end
      6'd14: begin fmt = F_I;  opc = OPC_LD;    f3 = 3'd5; end
      6'd15: begin fmt = F_S;  opc = OPC_ST;    f3 = 3'd0; end
      6'd16: begin fmt = F_S;  opc = OPC_ST;    f3 = 3'd1; end
      6'd17: begin fmt = F_S;  opc = OPC_ST;    f3 = 3'd2; end
      6'd18: begin fmt = F_I;  opc = OPC_OPI;   f3 = 3'd0; end
      6'd19: begin fmt = F_I;  opc = OPC_OPI;   f3 = 3'd2; end
      6'd20: begin fmt = F_I;  opc = OPC_OPI;   f3 = 3'd3; end
      6'd21: begin fmt = F_I;  opc = OPC_OPI;   f3 = 3'd4; end
      6'd22: begin fmt = F_I;  opc = OPC_OPI;   f3 = 3'd6; end
      6'd23: begin fmt = F_I;  opc = OPC_OPI;   f3 = 3'd7; end
      6'd24: begin fmt = F_SH; opc = OPC_OPI;   f3 = 3'd1; end
      6'd25: begin fmt = F_SH; opc = OPC_OPI;   f3 = 3'd5; end
      6'd26: begin fmt = F_SH; opc = OPC_OPI;   f3 = 3'd5; f7 = F7_ALT; end
      6'd27: begin fmt = F_R;  opc = OPC_OP;    f3 = 3'd0; end
      6'd28: begin fmt = F_R;  opc = OPC_OP;    f3 = 3'd0; f7 = F7_ALT; end
      6'd29: begin fmt = F_R;  opc = OPC_OP;    f3 = 3'd1; end
      6'd30: begin fmt = F_R;  opc = OPC_OP;    f3 = 3'd2; end
      6'd31: begin fmt = F_R;  opc = OPC_OP;    f3 = 3'd3; end
      6'd32: begin fmt = F_R;  opc = OPC_OP;    f3 = 3'd4; end
      6'd33: begin fmt = F_R;  opc = OPC_OP;    f3 = 3'd5; end
      6'd34: begin fmt = F_R;  opc = OPC_OP;    f3 = 3'd5; f7 = F7_ALT; end
      6'd35: begin fmt = F_R;  opc = OPC_OP;    f3 = 3'd6; end
      6'd36: begin fmt = F_R;  opc = OPC_OP;    f3 = 3'd7; end
      6'd37: fixed_word = 32'h0FF0000F;
      6'd38: fixed_word = 32'h00000073;
      6'd39: fixed_word = 32'h00100073;
      default: op_bad = 1'b1;
    endcase
  end

  // Field placement; B/J drop immediate bit 0, unused fields stay zero
  always_comb begin
    word = fixed_word;
    case (fmt)
      F_R:  word = {f7, in_rs2, in_rs1, f3, in_rd, opc};
      F_I:  word = {in_imm[11:0], in_rs1, f3, in_rd, opc};
      F_SH: word = {f7, in_imm[4:0], in_rs1, f3, in_rd, opc};
      F_S:  word = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opc};
      F_B:  word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3,
                    in_imm[4:1], in_imm[11], opc};
      F_U:  word = {in_imm[31:12], in_rd, opc};
      F_J:  word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                    in_rd, opc};
      default: word = fixed_word;
    endcase
  end

`ifdef INSTRUCTION_ENCODER_RANGE_CHECK_EN
  // A value fits a signed N-bit field when all bits from N-1 upward agree.
  logic range_bad;
  always_comb begin
    range_bad = 1'b0;
    case (fmt)
      F_I, F_S: range_bad = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      F_B:      range_bad = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
      F_J:      range_bad = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
      F_U:      range_bad = |in_imm[11:0];
      F_SH:     range_bad = |in_imm[31:5];
      default:  range_bad = 1'b0;
    endcase
  end
  assign enc_illegal = op_bad | range_bad;
`else
  assign enc_illegal = op_bad;
`endif

  assign enc_word = op_bad ? 32'h0 : word;

  // Output FIFO
  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head is masked while empty so reset shows zeros without clearing storage.
  assign out_word    = out_valid ? mem[rd_ptr][31:0] : 32'h0;
  assign out_illegal = out_valid ? mem[rd_ptr][32]   : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {enc_illegal, enc_word};
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Testbench for instruction_encoder: directed vectors with known machine words,
// backpressure, illegal ops, asynchronous reset, then randomized traffic
// checked against a table-driven reference encoder and an expected queue.
module tb_instruction_encoder;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_op = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_word;
  logic        out_illegal;

  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] exp_q[$];
  bit mon_en = 1'b0;
  bit rnd_rdy = 1'b0;

  instruction_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_illegal(out_illegal)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int br_f3  [6]  = '{0, 1, 4, 5, 6, 7};
  int ld_f3  [5]  = '{0, 1, 2, 4, 5};
  int opi_f3 [6]  = '{0, 2, 3, 4, 6, 7};
  int r_f3   [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};

  function automatic logic [32:0] ref_encode(input int op, input int rd, input int rs1,
                                             input int rs2, input logic [31:0] imm);
    logic [31:0] w;
    logic [31:0] d, s1, s2;
    bit rbad;
    int si;
    si = $signed(imm);
    d = 32'(rd) << 7;
    s1 = 32'(rs1) << 15;
    s2 = 32'(rs2) << 20;
    rbad = 1'b0;
    w = 32'h0;
    if (op == 0 || op == 1) begin
      w = (imm & 32'hFFFFF000) | d | ((op == 0) ? 32'h37 : 32'h17);
      rbad = (imm & 32'hFFF) != 0;
    end else if (op == 2) begin
      w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
          (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | d | 32'h6F;
      rbad = si < -1048576 || si > 1048574 || (si % 2) != 0;
    end else if (op == 3 || (op >= 10 && op <= 14) || (op >= 18 && op <= 23)) begin
      int f3;
      logic [31:0] opc;
      if (op == 3) begin f3 = 0; opc = 32'h67; end
      else if (op <= 14) begin f3 = ld_f3[op-10]; opc = 32'h03; end
      else begin f3 = opi_f3[op-18]; opc = 32'h13; end
      w = (imm << 20) | s1 | (32'(f3) << 12) | d | opc;
      rbad = si < -2048 || si > 2047;
    end else if (op >= 4 && op <= 9) begin
      w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | s2 | s1 |
          (32'(br_f3[op-4]) << 12) | (((imm >> 1) & 32'hF) << 8) |
          (((imm >> 11) & 1) << 7) | 32'h63;
      rbad = si < -4096 || si > 4094 || (si % 2) != 0;
    end else if (op >= 15 && op <= 17) begin
      w = (((imm >> 5) & 32'h7F) << 25) | s2 | s1 | (32'(op - 15) << 12) |
          ((imm & 32'h1F) << 7) | 32'h23;
      rbad = si < -2048 || si > 2047;
    end else if (op >= 24 && op <= 26) begin
      w = ((op == 26) ? 32'h40000000 : 32'h0) | ((imm & 32'h1F) << 20) | s1 |
          ((op == 24) ? 32'h1000 : 32'h5000) | d | 32'h13;
      rbad = si < 0 || si > 31;
    end else if (op >= 27 && op <= 36) begin
      w = ((op == 28 || op == 34) ? 32'h40000000 : 32'h0) | s2 | s1 |
          (32'(r_f3[op-27]) << 12) | d | 32'h33;
    end else if (op == 37) w = 32'h0FF0000F;
    else if (op == 38) w = 32'h00000073;
    else if (op == 39) w = 32'h00100073;
    else return {1'b1, 32'h0};
`ifdef INSTRUCTION_ENCODER_RANGE_CHECK_EN
    return {rbad, w};
`else
    return {1'b0, w};
`endif
  endfunction

  // ---------------- scoreboard monitor (samples on falling edge) ----------------
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      logic [32:0] e;
      check_eq("in_ready_level", 32'(in_ready), 32'(exp_q.size() != DEPTH));
      check_eq("out_valid_level", 32'(out_valid), 32'(exp_q.size() != 0));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("pop_empty", 32'(out_valid), 32'h0);
        end else begin
          e = exp_q.pop_front();
          check_eq("sb_word", out_word, e[31:0]);
          check_eq("sb_illegal", 32'(out_illegal), 32'(e[32]));
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(ref_encode(int'(in_op), int'(in_rd), int'(in_rs1), int'(in_rs2), in_imm));
    end
  end

  // Random consumer
  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Call just after a rising edge; returns 1 time unit after the accepting edge.
  task automatic push(input int op, input int rd, input int rs1, input int rs2,
                      input logic [31:0] imm);
    int k;
    in_op = op[5:0];
    in_rd = rd[4:0];
    in_rs1 = rs1[4:0];
    in_rs2 = rs2[4:0];
    in_imm = imm;
    in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) check_eq("push_timeout", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      step();
      k++;
    end
    check_eq("drain_empty", 32'(exp_q.size()), 32'h0);
  endtask

  int bnd[12] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                  1048574, 1048576, 31, 32};

  // ---------------- main sequence ----------------
  initial begin
    #12;
    check_eq("rst_out_valid", 32'(out_valid), 32'h0);
    check_eq("rst_in_ready", 32'(in_ready), 32'h1);
    check_eq("rst_out_word", out_word, 32'h0);
    check_eq("rst_out_illegal", 32'(out_illegal), 32'h0);
    rst_n = 1'b1;
    step();
    mon_en = 1'b1;

    // Latency and basic encodings
    out_ready = 1'b1;
    push(18, 1, 0, 0, 5);
    check_eq("addi_valid", 32'(out_valid), 32'h1);
    check_eq("addi_word", out_word, 32'h00500093);
    check_eq("addi_illegal", 32'(out_illegal), 32'h0);
    push(27, 3, 1, 2, 0);
    check_eq("add_word", out_word, 32'h002081B3);
    push(28, 3, 1, 2, 0);
    check_eq("sub_word", out_word, 32'h402081B3);
    push(4, 0, 1, 2, 8);
    check_eq("beq_word", out_word, 32'h00208463);
    push(2, 1, 0, 0, 2048);
    check_eq("jal_word", out_word, 32'h001000EF);
    push(0, 5, 0, 0, 32'h12345000);
    check_eq("lui_word", out_word, 32'h123452B7);
    push(26, 1, 1, 0, 3);
    check_eq("srai_word", out_word, 32'h4030D093);
    push(45, 1, 2, 3, 32'h1234);
    check_eq("illegal_word", out_word, 32'h0);
    check_eq("illegal_flag", 32'(out_illegal), 32'h1);
    push(37, 0, 0, 0, 0);
    check_eq("fence_word", out_word, 32'h0FF0000F);
`ifdef INSTRUCTION_ENCODER_RANGE_CHECK_EN
    push(18, 1, 0, 0, 4096);
    check_eq("range_addi_flag", 32'(out_illegal), 32'h1);
`endif
    drain();

    // Backpressure: third request must be held until the consumer is ready
    out_ready = 1'b0;
    push(18, 1, 0, 0, 1);
    push(18, 2, 0, 0, 2);
    check_eq("bp_full_ready", 32'(in_ready), 32'h0);
    fork
      push(18, 3, 0, 0, 3);
      begin
        repeat (3) step();
        check_eq("bp_held_valid", 32'(in_valid), 32'h1);
        check_eq("bp_held_ready", 32'(in_ready), 32'h0);
        out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with two entries queued
    out_ready = 1'b0;
    push(27, 1, 2, 3, 0);
    push(29, 4, 5, 6, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", 32'(out_valid), 32'h0);
    check_eq("arst_in_ready", 32'(in_ready), 32'h1);
    check_eq("arst_out_word", out_word, 32'h0);
    exp_q.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    push(38, 0, 0, 0, 0);
    check_eq("post_rst_ecall", out_word, 32'h00000073);
    drain();

    // Randomized traffic with random consumer
    rnd_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      logic [31:0] imm;
      case ($urandom_range(0, 2))
        0: imm = 32'($signed(32'($urandom_range(0, 63))) - 32);
        1: imm = $urandom;
        default: imm = 32'(bnd[$urandom_range(0, 11)]);
      endcase
      push($urandom_range(0, 47), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), imm);
      repeat ($urandom_range(0, 2)) step();
    end
    rnd_rdy = 1'b0;
    step();
    out_ready = 1'b1;
    drain();
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
RV32I instruction encoder: takes a decoded operation select plus register and immediate fields and assembles the 32-bit machine word. It is the inverse of the instruction decoder.
Feeds test-program generation, the boot-ROM builder and decoder round-trip verification, upstream of instruction memory.
Encoded words pass through a small output FIFO with valid/ready handshakes on both sides.

Parameters:
DEPTH, 2, output FIFO entries; power of two, minimum 2.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  request carries a valid operation
in_ready  output  1  encoder can accept a request this cycle
in_op  input  6  operation select, listed below
in_rd  input  5  destination register index
in_rs1  input  5  source register 1 index
in_rs2  input  5  source register 2 index
in_imm  input  32  signed byte-offset immediate; for U-type, the full upper value
out_valid  output  1  FIFO head holds an encoded word
out_ready  input  1  consumer takes the head word this cycle
out_word  output  32  encoded instruction at the FIFO head
out_illegal  output  1  head entry was flagged illegal

Behaviour:
- in_op map:
  - lui=0, auipc=1, jal=2, jalr=3
  - beq..bgeu=4..9 in the order beq, bne, blt, bge, bltu, bgeu
  - lb, lh, lw, lbu, lhu=10..14
  - sb, sh, sw=15..17
  - addi, slti, sltiu, xori, ori, andi=18..23
  - slli, srli, srai=24..26
  - add, sub, sll, slt, sltu, xor, srl, sra, or, and=27..36
  - fence=37, ecall=38, ebreak=39
  - 40..63 are illegal.
- Field placement and funct3/funct7/opcode values follow the RV32I base encoding.
  - B-type uses in_imm[12:1]; J-type uses in_imm[20:1]; bit 0 is dropped.
  - U-type uses in_imm[31:12].
  - Shifts: shamt=in_imm[4:0]; funct7=0100000 for srai, sub and sra, otherwise 0000000.
  - Fields the format does not use are ignored and encoded as zero.
  - Fixed words: fence=32'h0FF0000F, ecall=32'h00000073, ebreak=32'h00100073.
- Illegal op: the request is still accepted; entry stored with word=0 and illegal=1.
- Transfer rules:
  - Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
  - in_ready = (count != DEPTH); it does not depend on out_ready.
  - Encoding is combinational into the FIFO write port, so latency is 1 cycle: accepted at edge N, out_valid high after edge N when the FIFO was empty.
- FIFO ordering and wrap-around:
  - Strict FIFO order.
  - Read and write pointers are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits.
  - Simultaneous push and pop: count unchanged and both pointers advance; this is legal when empty only after the push lands, i.e. no bypass.
  - When empty, out_valid=0 and the out_word/out_illegal values are don't-care.
  - The producer must hold in_valid and fields stable until accepted.
- Reset values: count=0, pointers=0, out_valid=0, in_ready=1, out_word=0, out_illegal=0.
  - Reset asserted mid-operation discards all FIFO contents immediately (asynchronous).
  - The first accept after reset deasserts is permitted on the first clock edge.

Optional Feature:
Macro INSTRUCTION_ENCODER_RANGE_CHECK_EN.
- Defined: an entry is flagged out_illegal=1 if its immediate is out of range. The word is still emitted with the truncated immediate. Range limits:
  - I and S types: -2048..2047
  - B type: -4096..4094 and even
  - J type: -1048576..1048574 and even
  - U type: in_imm[11:0] must be 0
  - Shifts: 0..31
- Undefined: no range check; immediates are silently truncated; out_illegal is set only for op codes 40..63.

Test Plan:
- addi x1,x0,5 (op18, rd1, imm5), out_ready=1 -> one cycle later out_valid=1, out_word=32'h00500093, illegal=0.
- add x3,x1,x2 then sub x3,x1,x2 back-to-back -> 32'h002081B3 then 32'h402081B3 on consecutive cycles.
- Immediate formats:
  - beq x1,x2,+8 -> 32'h00208463
  - jal x1,+2048 -> 32'h001000EF
  - lui x5,32'h12345000 -> 32'h123452B7
  - srai x1,x1,3 -> 32'h4030D093
- Backpressure, out_ready=0, DEPTH=2, push three requests:
  - in_ready drops after the second accept and the third request is held.
  - Raising out_ready drains all three in order with no loss or duplication.
- Illegal and reset:
  - op=45 -> out_word=0, out_illegal=1.
  - With the macro defined, addi imm=4096 -> out_illegal=1.
  - Pulse rst_n low with 2 entries queued -> out_valid=0 and in_ready=1 immediately.
